speles_kontrolieris: RTL and testbench
======================================

# speles_kontrolieris

Round controller for the binary number game. It is the initiating side of the `Salidzinatajs` comparator: it produces the target `num_1` and the latched player guess `num_2`, then consumes the combinational `match` result. Each round it draws a pseudo-random 4-bit target, waits for a submit or a timeout, then scores the result. It sits between the board I/O (switches, button, LEDs) and the comparator.

## Interface
Parameters:
- `ROUND_TICKS`, default 100_000_000: clock cycles allowed per round before timeout (≥2).
- `RESULT_TICKS`, default 50_000_000: cycles the hit/miss result is held (≥1).
- `ROUNDS`, default 10: rounds per game (1..255).
- `LFSR_SEED`, default 8'hA5: LFSR reset value; must be nonzero.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level. A rising edge starts a game from IDLE or DONE.
- `submit` in 1: level, already debounced. Its rising edge submits the guess.
- `guess_sw` in [0:3]: player switches; bit 0 is MSB.
- `match` in 1: comparator result for the current `num_1`/`num_2`.
- `num_1` out [0:3]: registered target, to the comparator and display.
- `num_2` out [0:3]: registered latched guess, to the comparator.
- `round_active` out 1: high in PLAY.
- `hit` out 1: high throughout RESULT when the round was won.
- `miss` out 1: high throughout RESULT when the round was lost (wrong guess or timeout).
- `timeout` out 1: high throughout RESULT when the loss was a timeout.
- `score` out [7:0]: rounds won this game.
- `round_no` out [7:0]: current round, 1-based; 0 in IDLE.
- `game_over` out 1: high in DONE.

## Operation
- Edge detect: `start` and `submit` are registered once. An edge is `x & ~x_q`, so a held level acts once.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifts every cycle in every state, including IDLE.
- Candidate target: `lfsr[3:0]`, MSB-first into `num_1[0:3]`.
- Repeat avoidance: if the candidate equals the current `num_1`, load `candidate ^ 4'b0001` instead. Consecutive targets therefore always differ.
- States:
  - IDLE: wait for a start edge, then go to NEW. On that edge: `score`←0, `round_no`←0.
  - NEW (1 cycle):
    - Load `num_1` from the candidate.
    - `num_2`←~target, guaranteeing `match`=0 in PLAY.
    - `round_no`←`round_no`+1.
    - Timer←`ROUND_TICKS`-1.
    - Go to PLAY.
  - PLAY:
    - Submit edge: `num_2`←`guess_sw`, go to CHECK.
    - Otherwise, timer = 0: go to RESULT with a miss and timeout.
    - Otherwise: decrement the timer.
  - CHECK (1 cycle):
    - Sample `match`. The comparator has seen the new `num_2` for a full cycle.
    - `match`=1: `score`+1, go to RESULT with a hit.
    - `match`=0: go to RESULT with a miss.
  - RESULT:
    - Hold for `RESULT_TICKS` cycles.
    - Then go to DONE if `round_no`==`ROUNDS`, else to NEW.
  - DONE: `game_over`=1. `score` and `round_no` hold. A start edge behaves as in IDLE.
- Start edges outside IDLE and DONE are ignored. Submit edges outside PLAY are ignored.
- One guess per round. There are no retries.

## Timing
- Reset values:
  - State IDLE, LFSR=`LFSR_SEED`.
  - `num_1`=0, `num_2`=4'hF.
  - `score`=0, `round_no`=0.
  - All 1-bit outputs 0.
  - Edge registers 0.
- Reset mid-game aborts immediately; no partial score is kept.
- Start edge at cycle N: NEW at N+1, PLAY (`round_active`=1, new `num_1` valid) from N+2.
- Submit edge cycle S (in PLAY):
  - `num_2` updates at S+1 (CHECK).
  - `score` and `hit`/`miss` are valid at S+2.
- Timeout: PLAY lasts exactly `ROUND_TICKS` cycles without a submit, then `miss`=`timeout`=1 on the next cycle.
- A submit edge in the same cycle as timer = 0 counts as a submit; the timeout is not raised.
- RESULT lasts exactly `RESULT_TICKS` cycles. `hit`, `miss` and `timeout` are mutually consistent; `hit` and `miss` are never both high.
- `score` never exceeds `round_no` ≤ `ROUNDS`, so there is no overflow.

## Test plan
Bench uses `ROUND_TICKS`=8, `RESULT_TICKS`=2, `ROUNDS`=3, `LFSR_SEED`=8'h01, with a behavioural comparator.

- Reset, then idle 5 cycles:
  - `num_1`=0, `num_2`=F, `score`=0, `round_no`=0.
  - All flags 0; `round_active` stays 0.
- Start pulse; in PLAY drive `guess_sw`=`num_1` and pulse `submit`:
  - CHECK one cycle later.
  - Then `hit`=1 for 2 cycles, `score`=1, `round_no`=1.
- Next round: `guess_sw`=`num_1`^4'b1000 and submit:
  - `miss`=1, `timeout`=0, `score` unchanged.
  - New `num_1` ≠ previous target.
- Next round, no submit:
  - After 8 PLAY cycles, `miss`=`timeout`=1.
  - Then `game_over`=1 with `round_no`=3, `score`=1.
- Timer boundary and held input:
  - Submit edge exactly on the 8th PLAY cycle → treated as a submit; `timeout`=0.
  - `submit` held high across rounds → no second submission.
- Reset asserted during CHECK, and a start edge during PLAY:
  - Reset: next cycle is IDLE with all reset values.
  - Start edge in PLAY: ignored.

Source files
------------

// File: rtl/speles_kontrolieris.sv
`default_nettype none
// ============================================================================
// Module      : speles_kontrolieris
// Description : Round controller for the binary number game. Draws a
//               pseudo-random 4-bit target each round, waits for a player
//               submit or a timeout, scores the comparator result and
//               tracks rounds until the game is over.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               start, submit     - level inputs, rising edge acts once
//               guess_sw [0:3]    - player switches, bit 0 is MSB
//               match             - comparator result for num_1/num_2
//               num_1, num_2      - registered target / latched guess
//               round_active      - high while a round is being played
//               hit/miss/timeout  - round result, held during RESULT
//               score, round_no   - rounds won / current round (1-based)
//               game_over         - high once all rounds are played
// Revision    : 1.0 - initial release
// ============================================================================
module speles_kontrolieris #(
    parameter int         ROUND_TICKS  = 100_000_000,
    parameter int         RESULT_TICKS = 50_000_000,
    parameter int         ROUNDS       = 10,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       submit,
    input  logic [0:3] guess_sw,
    input  logic       match,
    output logic [0:3] num_1,
    output logic [0:3] num_2,
    output logic       round_active,
    output logic       hit,
    output logic       miss,
    output logic       timeout,
    output logic [7:0] score,
    output logic [7:0] round_no,
    output logic       game_over
);

    // One down-counter serves both the round window and the result hold.
    localparam int c_TIMER_MAX = (ROUND_TICKS > RESULT_TICKS) ? ROUND_TICKS : RESULT_TICKS;
    localparam int c_TIMER_W   = $clog2(c_TIMER_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_NEW    = 3'd1,
        S_PLAY   = 3'd2,
        S_CHECK  = 3'd3,
        S_RESULT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                 r_state;
    logic [7:0]             r_lfsr;
    logic                   r_start_q;
    logic                   r_submit_q;
    logic [0:3]             r_num1;
    logic [0:3]             r_num2;
    logic [7:0]             r_score;
    logic [7:0]             r_round;
    logic [c_TIMER_W-1:0]   r_timer;
    logic                   r_hit;
    logic                   r_miss;
    logic                   r_timeout;

    state_t                 w_state_n;
    logic [0:3]             w_num1_n;
    logic [0:3]             w_num2_n;
    logic [7:0]             w_score_n;
    logic [7:0]             w_round_n;
    logic [c_TIMER_W-1:0]   w_timer_n;
    logic                   w_hit_n;
    logic                   w_miss_n;
    logic                   w_timeout_n;

    logic                   w_start_edge;
    logic                   w_submit_edge;
    logic                   w_lfsr_fb;
    logic [0:3]             w_cand;
    logic [0:3]             w_target;

    assign w_start_edge  = start & ~r_start_q;
    assign w_submit_edge = submit & ~r_submit_q;

    // Taps for x^8 + x^6 + x^5 + x^4 + 1
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // lfsr[3] lands in num_1[0] (MSB). Flipping the value LSB on a repeat
    // guarantees consecutive targets differ.
    assign w_cand   = r_lfsr[3:0];
    assign w_target = (w_cand == r_num1) ? (w_cand ^ 4'b0001) : w_cand;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_lfsr     <= LFSR_SEED;
            r_start_q  <= 1'b0;
            r_submit_q <= 1'b0;
            r_num1     <= 4'h0;
            r_num2     <= 4'hF;
            r_score    <= 8'd0;
            r_round    <= 8'd0;
            r_timer    <= '0;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_lfsr     <= {r_lfsr[6:0], w_lfsr_fb};
            r_start_q  <= start;
            r_submit_q <= submit;
            r_num1     <= w_num1_n;
            r_num2     <= w_num2_n;
            r_score    <= w_score_n;
            r_round    <= w_round_n;
            r_timer    <= w_timer_n;
            r_hit      <= w_hit_n;
            r_miss     <= w_miss_n;
            r_timeout  <= w_timeout_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_num1_n    = r_num1;
        w_num2_n    = r_num2;
        w_score_n   = r_score;
        w_round_n   = r_round;
        w_timer_n   = r_timer;
        w_hit_n     = r_hit;
        w_miss_n    = r_miss;
        w_timeout_n = r_timeout;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_edge) begin
                    w_score_n = 8'd0;
                    w_round_n = 8'd0;
                    w_state_n = S_NEW;
                end
            end
            S_NEW: begin
                w_num1_n  = w_target;
                // Inverted guess cannot match, so PLAY never sees a stale hit.
                w_num2_n  = ~w_target;
                w_round_n = r_round + 8'd1;
                w_timer_n = c_TIMER_W'(ROUND_TICKS - 1);
                w_state_n = S_PLAY;
            end
            S_PLAY: begin
                // Submit wins over an expiring timer in the same cycle.
                if (w_submit_edge) begin
                    w_num2_n  = guess_sw;
                    w_state_n = S_CHECK;
                end else if (r_timer == '0) begin
                    w_miss_n    = 1'b1;
                    w_timeout_n = 1'b1;
                    w_timer_n   = c_TIMER_W'(RESULT_TICKS - 1);
                    w_state_n   = S_RESULT;
                end else begin
                    w_timer_n = r_timer - 1'b1;
                end
            end
            S_CHECK: begin
                w_timer_n = c_TIMER_W'(RESULT_TICKS - 1);
                w_state_n = S_RESULT;
                if (match) begin
                    w_score_n = r_score + 8'd1;
                    w_hit_n   = 1'b1;
                end else begin
                    w_miss_n  = 1'b1;
                end
            end
            S_RESULT: begin
                if (r_timer == '0) begin
                    w_hit_n     = 1'b0;
                    w_miss_n    = 1'b0;
                    w_timeout_n = 1'b0;
                    w_state_n   = (r_round == 8'(ROUNDS)) ? S_DONE : S_NEW;
                end else begin
                    w_timer_n = r_timer - 1'b1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    assign num_1        = r_num1;
    assign num_2        = r_num2;
    assign round_active = (r_state == S_PLAY);
    assign hit          = r_hit;
    assign miss         = r_miss;
    assign timeout      = r_timeout;
    assign score        = r_score;
    assign round_no     = r_round;
    assign game_over    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_speles_kontrolieris.sv
`default_nettype none
// ============================================================================
// Module      : tb_speles_kontrolieris
// Description : Directed self-checking bench for speles_kontrolieris with a
//               behavioural comparator and a reference LFSR for targets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_speles_kontrolieris;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       submit;
    logic [0:3] guess_sw;
    logic       match;
    logic [0:3] num_1;
    logic [0:3] num_2;
    logic       round_active;
    logic       hit;
    logic       miss;
    logic       timeout;
    logic [7:0] score;
    logic [7:0] round_no;
    logic       game_over;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] r_ref;
    logic [7:0] r_ref_prev;
    logic [3:0] exp_tgt;
    logic [3:0] prev_tgt;
    logic [3:0] old_tgt;

    speles_kontrolieris #(
        .ROUND_TICKS (8),
        .RESULT_TICKS(2),
        .ROUNDS      (3),
        .LFSR_SEED   (8'h01)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .submit      (submit),
        .guess_sw    (guess_sw),
        .match       (match),
        .num_1       (num_1),
        .num_2       (num_2),
        .round_active(round_active),
        .hit         (hit),
        .miss        (miss),
        .timeout     (timeout),
        .score       (score),
        .round_no    (round_no),
        .game_over   (game_over)
    );

    // Behavioural comparator
    assign match = (num_1 === num_2);

    always #5 clk = ~clk;

    // Reference x^8+x^6+x^5+x^4+1 sequence; r_ref_prev holds last cycle's value
    always @(posedge clk) begin
        if (rst) begin
            r_ref      <= 8'h01;
            r_ref_prev <= 8'h01;
        end else begin
            r_ref      <= {r_ref[6:0], r_ref[7] ^ r_ref[5] ^ r_ref[4] ^ r_ref[3]};
            r_ref_prev <= r_ref;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called in the first PLAY cycle: the target was drawn in the NEW cycle.
    task automatic new_target();
        logic [3:0] cand;
        cand    = r_ref_prev[3:0];
        exp_tgt = (cand == prev_tgt) ? (cand ^ 4'b0001) : cand;
        prev_tgt = exp_tgt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; submit = 1'b0; guess_sw = 4'h0;
        prev_tgt = 4'h0; exp_tgt = 4'h0; old_tgt = 4'h0;
        tick(); tick();
        rst = 1'b0;

        // Reset state and idle
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_round_active", round_active, 0);
        end
        chk("rst_num_1", num_1, 4'h0);
        chk("rst_num_2", num_2, 4'hF);
        chk("rst_score", score, 0);
        chk("rst_round_no", round_no, 0);
        chk("rst_flags", {hit, miss, timeout, game_over}, 4'b0000);

        // Game 1, round 1: correct guess
        start = 1'b1;
        tick();                                     // NEW
        start = 1'b0;
        chk("new_not_active", round_active, 0);
        tick();                                     // PLAY c1
        new_target();
        chk("g1r1_active", round_active, 1);
        chk("g1r1_num_1", num_1, exp_tgt);
        chk("g1r1_num_2_inv", num_2, 4'(~exp_tgt));
        chk("g1r1_round_no", round_no, 1);
        guess_sw = num_1;
        submit   = 1'b1;
        tick();                                     // CHECK
        chk("g1r1_check_inactive", round_active, 0);
        chk("g1r1_num_2_latched", num_2, exp_tgt);
        chk("g1r1_check_nohit", hit, 0);
        tick();                                     // RESULT 1
        chk("g1r1_hit", {hit, miss, timeout}, 3'b100);
        chk("g1r1_score", score, 1);
        chk("g1r1_round_no_res", round_no, 1);
        tick();                                     // RESULT 2
        chk("g1r1_hit_hold", hit, 1);
        tick();                                     // NEW
        chk("g1r1_hit_cleared", hit, 0);

        // Round 2: submit still held from round 1, then a wrong guess
        old_tgt = exp_tgt;
        tick();                                     // PLAY c1
        new_target();
        chk("g1r2_num_1", num_1, exp_tgt);
        chk("g1r2_differs", (num_1 != old_tgt), 1);
        tick();                                     // PLAY c2
        chk("g1r2_held_no_submit", round_active, 1);
        chk("g1r2_num_2_unchanged", num_2, 4'(~exp_tgt));
        submit = 1'b0;
        tick();                                     // PLAY c3
        guess_sw = num_1 ^ 4'b1000;
        submit   = 1'b1;
        tick();                                     // CHECK
        submit = 1'b0;
        tick();                                     // RESULT 1
        chk("g1r2_miss", {hit, miss, timeout}, 3'b010);
        chk("g1r2_score", score, 1);
        chk("g1r2_round_no", round_no, 2);
        tick(); tick();                             // RESULT 2, NEW

        // Round 3: timeout
        old_tgt = exp_tgt;
        tick();                                     // PLAY c1
        new_target();
        chk("g1r3_num_1", num_1, exp_tgt);
        chk("g1r3_differs", (num_1 != old_tgt), 1);
        repeat (7) tick();                          // PLAY c8
        chk("g1r3_c8_active", round_active, 1);
        chk("g1r3_c8_noflags", {hit, miss, timeout}, 3'b000);
        tick();                                     // RESULT 1
        chk("g1r3_timeout", {hit, miss, timeout}, 3'b011);
        chk("g1r3_inactive", round_active, 0);
        tick(); tick();                             // RESULT 2, DONE
        chk("g1_game_over", game_over, 1);
        chk("g1_round_no", round_no, 3);
        chk("g1_score", score, 1);
        tick();
        chk("g1_done_hold", {game_over, round_active}, 2'b10);
        chk("g1_done_score_hold", score, 1);

        // Game 2: restart from DONE, ignored start in PLAY, submit on last cycle
        start = 1'b1;
        tick();                                     // NEW
        start = 1'b0;
        chk("g2_score_cleared", score, 0);
        chk("g2_game_over_low", game_over, 0);
        tick();                                     // PLAY c1
        new_target();
        chk("g2r1_num_1", num_1, exp_tgt);
        chk("g2r1_round_no", round_no, 1);
        start = 1'b1;                               // edge in PLAY
        tick();                                     // PLAY c2
        start = 1'b0;
        chk("g2_start_ignored_active", round_active, 1);
        chk("g2_start_ignored_round", round_no, 1);
        repeat (6) tick();                          // PLAY c8
        chk("g2r1_c8_active", round_active, 1);
        guess_sw = num_1;
        submit   = 1'b1;
        tick();                                     // CHECK
        chk("g2r1_boundary_check", {round_active, timeout}, 2'b00);
        chk("g2r1_boundary_num_2", num_2, exp_tgt);
        tick();                                     // RESULT 1
        chk("g2r1_boundary_hit", {hit, miss, timeout}, 3'b100);
        chk("g2r1_score", score, 1);
        tick(); tick();                             // RESULT 2, NEW
        tick();                                     // PLAY c1 of round 2
        new_target();
        chk("g2r2_num_1", num_1, exp_tgt);
        tick();                                     // PLAY c2, submit still high
        chk("g2r2_held_no_submit", round_active, 1);
        submit = 1'b0;
        tick();                                     // PLAY c3
        submit = 1'b1;
        tick();                                     // CHECK
        chk("g2r2_in_check", round_active, 0);
        rst = 1'b1;
        tick();                                     // reset applied
        chk("rst2_active", round_active, 0);
        chk("rst2_num_1", num_1, 4'h0);
        chk("rst2_num_2", num_2, 4'hF);
        chk("rst2_score", score, 0);
        chk("rst2_round_no", round_no, 0);
        chk("rst2_flags", {hit, miss, timeout, game_over}, 4'b0000);
        rst = 1'b0; submit = 1'b0;
        prev_tgt = 4'h0;
        tick(); tick();
        chk("rst2_stays_idle", {round_active, round_no}, 9'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
